// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the HI/LO register pair.
// The restoring divider (DIV/DIVU) is built only when MULDIV_DIV_EN is defined.
module ex_muldiv #(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            start,
    input  logic            flush,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4'b1100);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(4'b1101);
`ifdef MULDIV_DIV_EN
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(4'b1010);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4'b1011);
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;      // {upper, lower}: running product, or {remainder, quotient}
    logic [31:0] opb;      // multiplicand / divisor magnitude
    logic        neg_lo;   // negate the product, or the quotient

    logic        op_mul, op_div, op_signed, accept;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, acc_next, prod_fix;
    logic [31:0] res_hi, res_lo;

`ifdef MULDIV_DIV_EN
    logic        div_op, neg_hi, div_zero;
    logic [31:0] rs_hold;
    logic [32:0] div_shift, div_diff;
    logic [63:0] div_next;

    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
`else
    assign op_div    = 1'b0;
    assign op_signed = (op == OP_MULT);
`endif

    assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign accept = (state == IDLE) && start && !flush && (op_mul || op_div);
    assign busy   = (state != IDLE);
    // The FSM already reads IDLE during reset, so the accept term is gated by rst_n.
    assign stall  = busy || (accept && rst_n);

    assign rs_mag = (op_signed && rs_val[31]) ? -rs_val : rs_val;
    assign rt_mag = (op_signed && rt_val[31]) ? -rt_val : rt_val;

    // Shift-add: add the multiplicand on the low bit, then shift the pair right.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};
    assign prod_fix = neg_lo ? -acc : acc;

`ifdef MULDIV_DIV_EN
    // Restoring divide: shift the pair left, keep the trial subtraction if it did not borrow.
    assign div_shift = acc[63:31];
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};
    assign acc_next  = div_op ? div_next : mul_next;

    assign res_hi = !div_op  ? prod_fix[63:32] :
                    div_zero ? rs_hold :
                    neg_hi   ? -acc[63:32] : acc[63:32];
    assign res_lo = !div_op  ? prod_fix[31:0] :
                    div_zero ? 32'hFFFF_FFFF :
                    neg_lo   ? -acc[31:0] : acc[31:0];
`else
    assign acc_next = mul_next;
    assign res_hi   = prod_fix[63:32];
    assign res_lo   = prod_fix[31:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_lo <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_DIV_EN
            div_op   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            rs_hold  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= RUN;
                        cnt    <= '0;
                        acc    <= {32'd0, rs_mag};
                        opb    <= rt_mag;
                        neg_lo <= op_signed && (rs_val[31] ^ rt_val[31]);
`ifdef MULDIV_DIV_EN
                        div_op   <= op_div;
                        neg_hi   <= op_signed && rs_val[31];
                        div_zero <= (rt_val == 32'd0);
                        rs_hold  <= rs_val;
`endif
                    end else if (start && !flush && op == OP_MTHI) begin
                        hi <= rs_val;
                    end else if (start && !flush && op == OP_MTLO) begin
                        lo <= rs_val;
                    end
                end
                // 32 step cycles plus one terminal-count cycle give the 34-edge latency.
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == 6'd32) begin
                        state <= FIXUP;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed, table-driven bench for ex_muldiv; DIV/DIVU expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv;
    localparam logic [3:0] MULT  = 4'b1000;
    localparam logic [3:0] MULTU = 4'b1001;
    localparam logic [3:0] DIV   = 4'b1010;
    localparam logic [3:0] DIVU  = 4'b1011;
    localparam logic [3:0] MTHI  = 4'b1100;
    localparam logic [3:0] MTLO  = 4'b1101;
    localparam int K_LONG  = 0;
    localparam int K_SHORT = 1;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          kind;
    } vec_t;

    logic        clk, rst_n, start, flush;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_mis = 0;
    vec_t vecs[$];

    ex_muldiv #(.OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .start(start), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input int k);
        vec_t v;
        v.op = o; v.rs = a; v.rt = b; v.hi = h; v.lo = l; v.kind = k;
        return v;
    endfunction

    // Counts edges until done is seen; records whether stall stayed high meanwhile.
    task automatic wait_done(output int n, output bit stall_ok);
        n = 0;
        stall_ok = 1'b1;
        while (n < 40) begin
            tick();
            n++;
            if (done) break;
            if (!stall) stall_ok = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit sok;
        op = v.op; rs_val = v.rs; rt_val = v.rt; start = 1'b1;
        #1;
        check($sformatf("v%0d_stall", idx), stall, v.kind == K_LONG);
        tick();
        start = 1'b0; op = 4'd0;
        if (v.kind == K_LONG) begin
            check($sformatf("v%0d_busy", idx), busy, 1'b1);
            wait_done(n, sok);
            check($sformatf("v%0d_latency", idx), n, 34);
            check($sformatf("v%0d_stall_held", idx), sok, 1'b1);
            check($sformatf("v%0d_hi", idx), hi, v.hi);
            check($sformatf("v%0d_lo", idx), lo, v.lo);
            tick();
            check($sformatf("v%0d_done_width", idx), done, 1'b0);
        end else begin
            check($sformatf("v%0d_busy", idx), busy, 1'b0);
            check($sformatf("v%0d_done", idx), done, 1'b0);
            check($sformatf("v%0d_hi", idx), hi, v.hi);
            check($sformatf("v%0d_lo", idx), lo, v.lo);
        end
    endtask

    initial begin
        int n;
        bit sok, seen;
        vec_t last;

        vecs.push_back(mk(MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, K_LONG));
        vecs.push_back(mk(MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, K_LONG));
        vecs.push_back(mk(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, K_LONG));
        vecs.push_back(mk(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, K_LONG));
        vecs.push_back(mk(MULT,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, K_LONG));
        vecs.push_back(mk(MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0002, K_LONG));
        vecs.push_back(mk(MTHI,  32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0000_0002, K_SHORT));
        vecs.push_back(mk(MTLO,  32'h0BAD_F00D, 32'h0,         32'hDEAD_BEEF, 32'h0BAD_F00D, K_SHORT));
        vecs.push_back(mk(4'b0000, 32'h5,       32'h5,         32'hDEAD_BEEF, 32'h0BAD_F00D, K_SHORT));
        vecs.push_back(mk(MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, K_LONG));
`ifdef MULDIV_DIV_EN
        vecs.push_back(mk(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, K_LONG));
        vecs.push_back(mk(DIVU,  32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, K_LONG));
        vecs.push_back(mk(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, K_LONG));
        vecs.push_back(mk(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, K_LONG));
        vecs.push_back(mk(DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, K_LONG));
        vecs.push_back(mk(DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, K_LONG));
`else
        vecs.push_back(mk(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h2345_6780, K_SHORT));
        vecs.push_back(mk(DIVU,  32'd100,       32'h0000_0000, 32'h0000_0001, 32'h2345_6780, K_SHORT));
`endif

        // Reset state, with an accept-looking request present during reset.
        rst_n = 1'b0; flush = 1'b0; start = 1'b1; op = MULT; rs_val = 32'd5; rt_val = 32'd6;
        #3;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_stall", stall, 1'b0);
        #19;
        start = 1'b0;
        rst_n = 1'b1;

        // First vector is accepted on the first edge after release.
        foreach (vecs[i]) run_vec(vecs[i], i);

        last = vecs[vecs.size()-1];
        run_vec(mk(MTLO, 32'h5555_AAAA, 32'h0, last.hi, 32'h5555_AAAA, K_SHORT), 50);
        run_vec(mk(MTHI, 32'hAAAA_5555, 32'h0, 32'hAAAA_5555, 32'h5555_AAAA, K_SHORT), 51);

        // Flush at iteration 10 aborts; a new op is accepted right after.
        op = MULTU; rs_val = 32'h10; rt_val = 32'h10; start = 1'b1;
        tick();
        start = 1'b0; op = 4'd0; seen = 1'b0;
        repeat (10) begin
            tick();
            if (done) seen = 1'b1;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", busy, 1'b0);
        check("fl_done", seen | done, 1'b0);
        check("fl_hi", hi, 32'hAAAA_5555);
        check("fl_lo", lo, 32'h5555_AAAA);
        run_vec(mk(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, K_LONG), 60);

        // Flush during the FIXUP cycle: no write, no done.
        op = MULTU; rs_val = 32'd2; rt_val = 32'd2; start = 1'b1;
        tick();
        start = 1'b0; op = 4'd0;
        repeat (33) tick();
        check("fx_busy_before", busy, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fx_done", done, 1'b0);
        check("fx_busy", busy, 1'b0);
        check("fx_hi", hi, 32'd0);
        check("fx_lo", lo, 32'd15);

        // Flush together with an accept condition: nothing is accepted.
        op = MULT; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        check("fa_stall", stall, 1'b0);
        tick();
        start = 1'b0; flush = 1'b0; op = 4'd0;
        check("fa_busy", busy, 1'b0);
        check("fa_lo", lo, 32'd15);

        // MTHI while busy is ignored; MTLO in IDLE is taken without stall.
        op = MULTU; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; op = 4'd0;
        repeat (5) tick();
        op = MTHI; rs_val = 32'h1234_5678; start = 1'b1;
        #1;
        check("mb_stall", stall, 1'b1);
        tick();
        start = 1'b0; op = 4'd0;
        wait_done(n, sok);
        check("mb_latency", n, 28);
        check("mb_hi", hi, 32'd0);
        check("mb_lo", lo, 32'd6);
        run_vec(mk(MTLO, 32'hCAFE_BABE, 32'h0, 32'd0, 32'hCAFE_BABE, K_SHORT), 70);

        // Asynchronous reset at iteration 20 discards the operation.
        op = MULT; rs_val = 32'hFFFF_FFFD; rt_val = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; op = 4'd0;
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        op = MULT; start = 1'b1;
        #1;
        check("rm_hi", hi, 32'd0);
        check("rm_lo", lo, 32'd0);
        check("rm_busy", busy, 1'b0);
        check("rm_stall", stall, 1'b0);
        start = 1'b0; op = 4'd0;
        tick();
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("rm_no_done", seen, 1'b0);
        check("rm_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
